wb_io_mux_n: RTL and testbench
==============================

# wb_io_mux_n

Parametrised, registered Wishbone B4 classic 1-to-N peripheral interconnect for the SoC peripheral bus. It decodes a single master request against N base/mask windows, forwards it to one slave (SPI, I2C, UART or new peripherals), and returns the slave's data with ack or err. Compared with the fixed four-slave interconnect, it adds:
- a configurable slave count;
- an unmapped-address error response;
- a per-transaction timeout watchdog;
- master-abort handling;
- a faulting-address capture port.

## Interface
Parameters:
- N_SLAVES, 4, number of slave ports (1..16)
- AW, 32, address width
- DW, 32, data width
- SLAVE_BASE, {32'h1000_3000, 32'h1000_2000, 32'h1000_1000, 32'h1000_0000}, N_SLAVES×AW packed base addresses; slave i occupies bits [i*AW +: AW]
- SLAVE_MASK, {4{32'hFFFF_F000}}, N_SLAVES×AW packed decode masks
- TIMEOUT, 255, cycles waited for a slave response; 0 disables the watchdog

Ports (one clock; reset is synchronous and active-high):
- wb_clk  in  1  clock
- wb_rst  in  1  synchronous active-high reset
- wb_m2s_adr  in  AW  master address
- wb_m2s_dat  in  DW  master write data
- wb_m2s_sel  in  DW/8  byte selects
- wb_m2s_we  in  1  write enable
- wb_m2s_cyc  in  1  cycle valid
- wb_m2s_stb  in  1  strobe
- wb_s2m_dat  out  DW  read data to master
- wb_s2m_ack  out  1  transfer complete
- wb_s2m_err  out  1  transfer failed
- wb_s_adr_o  out  N_SLAVES×AW  per-slave address
- wb_s_dat_o  out  N_SLAVES×DW  per-slave write data
- wb_s_sel_o  out  N_SLAVES×DW/8  per-slave byte selects
- wb_s_we_o  out  N_SLAVES  per-slave write enable
- wb_s_cyc_o  out  N_SLAVES  per-slave cycle
- wb_s_stb_o  out  N_SLAVES  per-slave strobe
- wb_s_dat_i  in  N_SLAVES×DW  per-slave read data
- wb_s_ack_i  in  N_SLAVES  per-slave ack
- wb_s_err_i  in  N_SLAVES  per-slave err
- err_adr_o  out  AW  address of the most recent failed transfer
- err_pulse_o  out  1  one-cycle pulse per failed transfer

## Operation
State machine: IDLE, ACTIVE, RESP.

- **IDLE:**
  - On wb_m2s_cyc & wb_m2s_stb, latch adr, dat, sel and we.
  - Decode: slave i hits when (adr & MASK_i) == (BASE_i & MASK_i). On multiple hits the lowest index wins.
  - On a hit: latch the index, clear the timeout counter, go to ACTIVE.
  - On no hit: go to RESP with err set; the request is never forwarded.
- **ACTIVE:**
  - Drive the selected slave's cyc, stb and latched fields. All other slaves see cyc = stb = 0; their adr, dat and sel are don't-care.
  - Selected slave asserts ack: capture its dat, go to RESP with ack set.
  - Selected slave asserts err: go to RESP with err set. If ack and err arrive in the same cycle, err wins.
  - Otherwise the counter increments. At counter == TIMEOUT−1 with no response (TIMEOUT ≠ 0), go to RESP with err set and drop the slave's cyc/stb. A slave ack in that same cycle takes precedence over the timeout.
  - Master drops wb_m2s_cyc: abort. Go to IDLE and deassert the slave's cyc/stb next cycle; no ack or err is issued.
  - Responses from non-selected slaves are ignored.
- **RESP:**
  - Assert wb_s2m_ack or wb_s2m_err for exactly one cycle.
  - wb_s2m_dat holds the captured read data (0 on err and on writes).
  - Return to IDLE. A new request is accepted no earlier than the cycle after RESP.
- **Error capture:** every err response loads err_adr_o with the latched address and pulses err_pulse_o in the same cycle as wb_s2m_err.
- **Counter width:** $clog2(TIMEOUT+1), saturating.

## Timing
- **Reset:** state IDLE; all slave cyc/stb, wb_s2m_ack, wb_s2m_err and err_pulse_o at 0; wb_s2m_dat = 0, err_adr_o = 0, counter = 0.
- **Reset mid-transaction:** returns to IDLE the next cycle with no response issued.
- **Latency:** request sampled at cycle 0; slave stb asserted at cycle 1; slave ack at cycle k ≥ 1 gives master ack at cycle k+1.
  - Minimum request-to-ack: 2 cycles.
  - Unmapped address: err at cycle 1.
  - Timeout: slave stb covers cycles 1..TIMEOUT; err at cycle TIMEOUT+1.
- The master must hold stb and its fields stable until ack or err (classic handshake). Field changes after cycle 0 are ignored.
- Back-to-back throughput: one transfer per 3 cycles with zero-wait-state slaves.

## Test plan
- Write 0xA5 to 0x1000_2004 (slave 2 acks one cycle after stb) -> slave 2 sees adr 0x1000_2004, we = 1, dat 0xA5 from cycle 1; master ack at cycle 3; no other slave cyc asserted.
- Read 0x1000_0008 with slave 0 returning 0x0000_003C after 3 wait states -> wb_s2m_dat = 0x3C with ack at cycle 5, for exactly one cycle.
- Read unmapped 0x2000_0000 -> err at cycle 1, err_adr_o = 0x2000_0000, err_pulse_o high for 1 cycle, no slave cyc asserted.
- TIMEOUT = 8, slave 3 never acks -> slave 3 cyc high for cycles 1..8, err at cycle 9; a late ack at cycle 10 is ignored.
- Master drops cyc at cycle 2 of a slave-1 access -> slave 1 cyc low at cycle 3, no ack or err; the next request decodes normally.
- Simultaneous ack + err from the selected slave, plus wb_rst pulsed mid-ACTIVE in a second transfer -> err wins in the first case; after reset all outputs are 0 and state is IDLE.

Source files
------------

// File: rtl/wb_io_mux_n.sv
// Registered Wishbone B4 classic 1-to-N interconnect with address decode,
// unmapped-address error, per-transaction timeout, master abort and
// faulting-address capture.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for cyc & stb; decodes and latches the request
// ACTIVE | request forwarded to the selected slave, waiting for ack/err
// RESP   | one-cycle ack or err back to the master
module wb_io_mux_n #(
   parameter int N_SLAVES = 4,
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter logic [N_SLAVES*AW-1:0] SLAVE_BASE =
      {32'h1000_3000, 32'h1000_2000, 32'h1000_1000, 32'h1000_0000},
   parameter logic [N_SLAVES*AW-1:0] SLAVE_MASK = {4{32'hFFFF_F000}},
   parameter int TIMEOUT  = 255
) (
   input  logic                       wb_clk,
   input  logic                       wb_rst,
   input  logic [AW-1:0]              wb_m2s_adr,
   input  logic [DW-1:0]              wb_m2s_dat,
   input  logic [DW/8-1:0]            wb_m2s_sel,
   input  logic                       wb_m2s_we,
   input  logic                       wb_m2s_cyc,
   input  logic                       wb_m2s_stb,
   output logic [DW-1:0]              wb_s2m_dat,
   output logic                       wb_s2m_ack,
   output logic                       wb_s2m_err,
   output logic [N_SLAVES*AW-1:0]     wb_s_adr_o,
   output logic [N_SLAVES*DW-1:0]     wb_s_dat_o,
   output logic [N_SLAVES*DW/8-1:0]   wb_s_sel_o,
   output logic [N_SLAVES-1:0]        wb_s_we_o,
   output logic [N_SLAVES-1:0]        wb_s_cyc_o,
   output logic [N_SLAVES-1:0]        wb_s_stb_o,
   input  logic [N_SLAVES*DW-1:0]     wb_s_dat_i,
   input  logic [N_SLAVES-1:0]        wb_s_ack_i,
   input  logic [N_SLAVES-1:0]        wb_s_err_i,
   output logic [AW-1:0]              err_adr_o,
   output logic                       err_pulse_o
);

   localparam int SW = DW / 8;
   localparam int IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
   // A zero TIMEOUT still needs a legal one-bit counter.
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     adr_q;
   logic [DW-1:0]     wdat_q;
   logic [SW-1:0]     sel_q;
   logic              we_q;
   logic [IW-1:0]     idx_q;
   logic [CW-1:0]     cnt_q;
   logic [DW-1:0]     rdat_q;
   logic              ack_q, err_q;
   logic [AW-1:0]     err_adr_q;

   logic              hit;
   logic [IW-1:0]     hit_idx;
   logic              ld_req, set_ack, set_err, cnt_clr, cnt_inc;
   logic              sel_ack, sel_err;
   logic [DW-1:0]     sel_dat;
   logic [N_SLAVES-1:0] cyc_vec;

   // Address decode; scanning downwards lets the lowest matching index win.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = N_SLAVES - 1; i >= 0; i--) begin
         if ((wb_m2s_adr & SLAVE_MASK[i*AW +: AW]) ==
             (SLAVE_BASE[i*AW +: AW] & SLAVE_MASK[i*AW +: AW])) begin
            hit     = 1'b1;
            hit_idx = IW'(i);
         end
      end
   end

   assign sel_ack = wb_s_ack_i[idx_q];
   assign sel_err = wb_s_err_i[idx_q];
   assign sel_dat = wb_s_dat_i[int'(idx_q)*DW +: DW];

   // State register.
   always_ff @(posedge wb_clk) begin
      if (wb_rst) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and datapath strobes; abort beats err, err beats ack, ack beats timeout.
   always_comb begin
      state_d = state_q;
      ld_req  = 1'b0;
      set_ack = 1'b0;
      set_err = 1'b0;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      case (state_q)
         IDLE: begin
            if (wb_m2s_cyc && wb_m2s_stb) begin
               ld_req = 1'b1;
               if (hit) begin
                  state_d = ACTIVE;
                  cnt_clr = 1'b1;
               end else begin
                  state_d = RESP;
                  set_err = 1'b1;
               end
            end
         end
         ACTIVE: begin
            if (!wb_m2s_cyc) begin
               state_d = IDLE;
            end else if (sel_err) begin
               state_d = RESP;
               set_err = 1'b1;
            end else if (sel_ack) begin
               state_d = RESP;
               set_ack = 1'b1;
            end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
               state_d = RESP;
               set_err = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request latch, watchdog counter, response and error-capture registers.
   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         adr_q     <= '0;
         wdat_q    <= '0;
         sel_q     <= '0;
         we_q      <= 1'b0;
         idx_q     <= '0;
         cnt_q     <= '0;
         rdat_q    <= '0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         err_adr_q <= '0;
      end else begin
         if (ld_req) begin
            adr_q  <= wb_m2s_adr;
            wdat_q <= wb_m2s_dat;
            sel_q  <= wb_m2s_sel;
            we_q   <= wb_m2s_we;
            idx_q  <= hit_idx;
         end
         if (cnt_clr)
            cnt_q <= '0;
         else if (cnt_inc && cnt_q != {CW{1'b1}})
            cnt_q <= cnt_q + 1'b1;
         ack_q <= set_ack;
         err_q <= set_err;
         if (set_ack)
            rdat_q <= we_q ? '0 : sel_dat;
         else if (set_err)
            rdat_q <= '0;
         // An unmapped request errors in the same cycle it is latched.
         if (set_err)
            err_adr_q <= ld_req ? wb_m2s_adr : adr_q;
      end
   end

   // Only the selected slave sees cyc/stb, and only while ACTIVE.
   always_comb begin
      cyc_vec = '0;
      if (state_q == ACTIVE) cyc_vec[idx_q] = 1'b1;
   end

   assign wb_s_cyc_o  = cyc_vec;
   assign wb_s_stb_o  = cyc_vec;
   assign wb_s_we_o   = cyc_vec & {N_SLAVES{we_q}};
   assign wb_s_adr_o  = {N_SLAVES{adr_q}};
   assign wb_s_dat_o  = {N_SLAVES{wdat_q}};
   assign wb_s_sel_o  = {N_SLAVES{sel_q}};

   assign wb_s2m_dat  = rdat_q;
   assign wb_s2m_ack  = ack_q;
   assign wb_s2m_err  = err_q;
   assign err_adr_o   = err_adr_q;
   assign err_pulse_o = err_q;

endmodule

// File: tb/tb_wb_io_mux_n.sv
// Directed bench for wb_io_mux_n with TIMEOUT = 8 and the default address map.
module tb_wb_io_mux_n;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic                wb_clk = 1'b0;
   logic                wb_rst;
   logic [AW-1:0]       wb_m2s_adr;
   logic [DW-1:0]       wb_m2s_dat;
   logic [DW/8-1:0]     wb_m2s_sel;
   logic                wb_m2s_we, wb_m2s_cyc, wb_m2s_stb;
   logic [DW-1:0]       wb_s2m_dat;
   logic                wb_s2m_ack, wb_s2m_err;
   logic [N*AW-1:0]     wb_s_adr_o;
   logic [N*DW-1:0]     wb_s_dat_o;
   logic [N*DW/8-1:0]   wb_s_sel_o;
   logic [N-1:0]        wb_s_we_o, wb_s_cyc_o, wb_s_stb_o;
   logic [N*DW-1:0]     wb_s_dat_i;
   logic [N-1:0]        wb_s_ack_i, wb_s_err_i;
   logic [AW-1:0]       err_adr_o;
   logic                err_pulse_o;

   int checks   = 0;
   int failures = 0;

   wb_io_mux_n #(.TIMEOUT(8)) dut (
      .wb_clk(wb_clk), .wb_rst(wb_rst),
      .wb_m2s_adr(wb_m2s_adr), .wb_m2s_dat(wb_m2s_dat), .wb_m2s_sel(wb_m2s_sel),
      .wb_m2s_we(wb_m2s_we), .wb_m2s_cyc(wb_m2s_cyc), .wb_m2s_stb(wb_m2s_stb),
      .wb_s2m_dat(wb_s2m_dat), .wb_s2m_ack(wb_s2m_ack), .wb_s2m_err(wb_s2m_err),
      .wb_s_adr_o(wb_s_adr_o), .wb_s_dat_o(wb_s_dat_o), .wb_s_sel_o(wb_s_sel_o),
      .wb_s_we_o(wb_s_we_o), .wb_s_cyc_o(wb_s_cyc_o), .wb_s_stb_o(wb_s_stb_o),
      .wb_s_dat_i(wb_s_dat_i), .wb_s_ack_i(wb_s_ack_i), .wb_s_err_i(wb_s_err_i),
      .err_adr_o(err_adr_o), .err_pulse_o(err_pulse_o)
   );

   always #5 wb_clk = ~wb_clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
   task automatic tick();
      @(posedge wb_clk);
      #1;
   endtask

   task automatic req(input logic [31:0] adr, input logic [31:0] dat, input logic we);
      wb_m2s_adr = adr;
      wb_m2s_dat = dat;
      wb_m2s_sel = 4'hF;
      wb_m2s_we  = we;
      wb_m2s_cyc = 1'b1;
      wb_m2s_stb = 1'b1;
   endtask

   task automatic drop();
      wb_m2s_cyc = 1'b0;
      wb_m2s_stb = 1'b0;
   endtask

   initial begin
      wb_rst = 1'b1;
      wb_m2s_adr = '0; wb_m2s_dat = '0; wb_m2s_sel = '0; wb_m2s_we = 1'b0;
      wb_m2s_cyc = 1'b0; wb_m2s_stb = 1'b0;
      wb_s_dat_i = '0; wb_s_ack_i = '0; wb_s_err_i = '0;
      repeat (3) tick();
      wb_rst = 1'b0;

      // reset state
      check("rst_cyc", wb_s_cyc_o, 4'b0000);
      check("rst_stb", wb_s_stb_o, 4'b0000);
      check("rst_ack", wb_s2m_ack, 1'b0);
      check("rst_err", wb_s2m_err, 1'b0);
      check("rst_pulse", err_pulse_o, 1'b0);
      check("rst_dat", wb_s2m_dat, 32'h0);
      check("rst_erradr", err_adr_o, 32'h0);

      // write 0xA5 to slave 2, slave acks one cycle after stb
      req(32'h1000_2004, 32'h0000_00A5, 1'b1);
      check("w_c0_cyc", wb_s_cyc_o, 4'b0000);
      tick();
      check("w_c1_cyc", wb_s_cyc_o, 4'b0100);
      check("w_c1_stb", wb_s_stb_o, 4'b0100);
      check("w_c1_we", wb_s_we_o, 4'b0100);
      check("w_c1_adr", wb_s_adr_o[2*AW +: AW], 32'h1000_2004);
      check("w_c1_dat", wb_s_dat_o[2*DW +: DW], 32'h0000_00A5);
      check("w_c1_ack", wb_s2m_ack, 1'b0);
      tick();
      check("w_c2_cyc", wb_s_cyc_o, 4'b0100);
      wb_s_ack_i[2] = 1'b1;
      tick();
      wb_s_ack_i = '0;
      check("w_c3_ack", wb_s2m_ack, 1'b1);
      check("w_c3_err", wb_s2m_err, 1'b0);
      check("w_c3_dat", wb_s2m_dat, 32'h0);
      check("w_c3_cyc", wb_s_cyc_o, 4'b0000);
      drop();
      tick();
      check("w_c4_ack", wb_s2m_ack, 1'b0);

      // read slave 0 with 3 wait states
      req(32'h1000_0008, 32'h0, 1'b0);
      tick();
      check("r_c1_cyc", wb_s_cyc_o, 4'b0001);
      check("r_c1_we", wb_s_we_o, 4'b0000);
      for (int c = 1; c <= 3; c++) begin
         check("r_wait_ack", wb_s2m_ack, 1'b0);
         tick();
      end
      wb_s_dat_i = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h0000_003C};
      wb_s_ack_i[0] = 1'b1;
      check("r_c4_ack", wb_s2m_ack, 1'b0);
      tick();
      wb_s_ack_i = '0;
      check("r_c5_ack", wb_s2m_ack, 1'b1);
      check("r_c5_dat", wb_s2m_dat, 32'h0000_003C);
      drop();
      tick();
      check("r_c6_ack", wb_s2m_ack, 1'b0);

      // unmapped read
      req(32'h2000_0000, 32'h0, 1'b0);
      tick();
      check("u_c1_err", wb_s2m_err, 1'b1);
      check("u_c1_ack", wb_s2m_ack, 1'b0);
      check("u_c1_pulse", err_pulse_o, 1'b1);
      check("u_c1_erradr", err_adr_o, 32'h2000_0000);
      check("u_c1_cyc", wb_s_cyc_o, 4'b0000);
      drop();
      tick();
      check("u_c2_err", wb_s2m_err, 1'b0);
      check("u_c2_pulse", err_pulse_o, 1'b0);
      check("u_c2_erradr", err_adr_o, 32'h2000_0000);

      // timeout on slave 3; a stray ack from slave 0 is ignored
      req(32'h1000_3010, 32'h0, 1'b0);
      tick();
      for (int c = 1; c <= 8; c++) begin
         check("t_cyc", wb_s_cyc_o, 4'b1000);
         check("t_err", wb_s2m_err, 1'b0);
         check("t_ack", wb_s2m_ack, 1'b0);
         wb_s_ack_i[0] = (c == 3);
         tick();
      end
      wb_s_ack_i = '0;
      check("t_c9_err", wb_s2m_err, 1'b1);
      check("t_c9_pulse", err_pulse_o, 1'b1);
      check("t_c9_erradr", err_adr_o, 32'h1000_3010);
      check("t_c9_cyc", wb_s_cyc_o, 4'b0000);
      drop();
      tick();
      wb_s_ack_i[3] = 1'b1;
      tick();
      wb_s_ack_i = '0;
      check("t_late_ack", wb_s2m_ack, 1'b0);
      check("t_late_cyc", wb_s_cyc_o, 4'b0000);

      // master abort on slave 1
      req(32'h1000_1000, 32'h0, 1'b0);
      tick();
      check("a_c1_cyc", wb_s_cyc_o, 4'b0010);
      tick();
      drop();
      check("a_c2_cyc", wb_s_cyc_o, 4'b0010);
      tick();
      check("a_c3_cyc", wb_s_cyc_o, 4'b0000);
      check("a_c3_ack", wb_s2m_ack, 1'b0);
      check("a_c3_err", wb_s2m_err, 1'b0);
      tick();
      check("a_c4_ack", wb_s2m_ack, 1'b0);
      check("a_c4_err", wb_s2m_err, 1'b0);
      req(32'h1000_1004, 32'h0, 1'b0);
      tick();
      check("a2_c1_cyc", wb_s_cyc_o, 4'b0010);
      wb_s_dat_i[1*DW +: DW] = 32'h0000_1234;
      wb_s_ack_i[1] = 1'b1;
      tick();
      wb_s_ack_i = '0;
      check("a2_c2_ack", wb_s2m_ack, 1'b1);
      check("a2_c2_dat", wb_s2m_dat, 32'h0000_1234);
      drop();
      tick();

      // simultaneous ack and err: err wins
      req(32'h1000_2000, 32'h0, 1'b0);
      tick();
      wb_s_dat_i[2*DW +: DW] = 32'h0000_DEAD;
      wb_s_ack_i[2] = 1'b1;
      wb_s_err_i[2] = 1'b1;
      tick();
      wb_s_ack_i = '0;
      wb_s_err_i = '0;
      check("ae_err", wb_s2m_err, 1'b1);
      check("ae_ack", wb_s2m_ack, 1'b0);
      check("ae_dat", wb_s2m_dat, 32'h0);
      check("ae_pulse", err_pulse_o, 1'b1);
      check("ae_erradr", err_adr_o, 32'h1000_2000);
      drop();
      tick();

      // reset mid-ACTIVE
      req(32'h1000_0000, 32'h0, 1'b0);
      tick();
      check("rm_c1_cyc", wb_s_cyc_o, 4'b0001);
      wb_rst = 1'b1;
      drop();
      tick();
      wb_rst = 1'b0;
      check("rm_cyc", wb_s_cyc_o, 4'b0000);
      check("rm_ack", wb_s2m_ack, 1'b0);
      check("rm_err", wb_s2m_err, 1'b0);
      check("rm_pulse", err_pulse_o, 1'b0);
      check("rm_dat", wb_s2m_dat, 32'h0);
      check("rm_erradr", err_adr_o, 32'h0);
      tick();
      check("rm2_cyc", wb_s_cyc_o, 4'b0000);
      check("rm2_ack", wb_s2m_ack, 1'b0);
      check("rm2_err", wb_s2m_err, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
